// File: rtl/binary_search_ctrl_if.sv
// Comparator-side bundle between the search controller and the eq/lt/gt magnitude comparator.
// master: controller (drives guess and status, samples start and flags).
// slave: environment (drives start and flags, observes guess and status).
interface binary_search_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] guess;
  logic             eq;
  logic             lt;
  logic             gt;
  logic             busy;
  logic             done;
  logic             found;
  logic             error;
  logic [WIDTH-1:0] result;
  logic [3:0]       steps;

  modport master (
    input  start, eq, lt, gt,
    output guess, busy, done, found, error, result, steps
  );

  modport slave (
    output start, eq, lt, gt,
    input  guess, busy, done, found, error, result, steps
  );
endinterface

// File: rtl/binary_search_ctrl.sv
// Successive-approximation search controller: drives a registered guess into a
// combinational comparator and narrows [lo,hi] by binary search until eq.
// Latency: one cycle per compare, done on the terminal compare edge (1..9 cycles).
// No backpressure: start is only sampled in IDLE/DONE and ignored while busy.
// Ports: clk, reset (async, active-high), bus (master modport: start/eq/lt/gt in;
// guess/busy/done/found/error/result/steps out).
module binary_search_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  binary_search_ctrl_if.master  bus
);

  localparam logic [WIDTH-1:0] MAX_VAL  = '1;
  localparam logic [WIDTH-1:0] MID_INIT = MAX_VAL >> 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_guess;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_steps;
  logic             r_busy;
  logic             r_done;
  logic             r_found;
  logic             r_error;

  logic             w_onehot;
  logic             w_edge_err;
  logic             w_empty;
  logic [WIDTH-1:0] w_lo_nxt;
  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_mid;

  always_comb begin
    // Odd parity rules out 0 or 2 flags; the AND term rules out all three.
    w_onehot   = (bus.eq ^ bus.lt ^ bus.gt) & ~(bus.eq & bus.lt & bus.gt);
    // lt at the top or gt at the bottom has nowhere left to go.
    w_edge_err = (bus.lt && (r_guess == MAX_VAL)) || (bus.gt && (r_guess == '0));
    w_lo_nxt   = r_lo;
    w_hi_nxt   = r_hi;
    if (bus.lt) begin
      w_lo_nxt = r_guess + 1'b1;
    end else if (bus.gt) begin
      w_hi_nxt = r_guess - 1'b1;
    end
    w_empty = (w_lo_nxt > w_hi_nxt);
    // Sum carried at WIDTH+1 bits so lo+hi near the top cannot wrap.
    w_sum   = {1'b0, w_lo_nxt} + {1'b0, w_hi_nxt};
    w_mid   = w_sum[WIDTH:1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_lo     <= '0;
      r_hi     <= '0;
      r_guess  <= '0;
      r_result <= '0;
      r_steps  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_found  <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (bus.start) begin
            r_state <= COMPARE;
            r_lo    <= '0;
            r_hi    <= MAX_VAL;
            r_guess <= MID_INIT;
            r_steps <= '0;
            r_found <= 1'b0;
            r_error <= 1'b0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end

        COMPARE: begin
          r_steps <= r_steps + 4'd1;
          if (!w_onehot) begin
            r_state <= DONE;
            r_error <= 1'b1;
            r_found <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (bus.eq) begin
            r_state  <= DONE;
            r_found  <= 1'b1;
            r_result <= r_guess;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end else if (w_edge_err || w_empty) begin
            r_state <= DONE;
            r_error <= 1'b1;
            r_found <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_lo    <= w_lo_nxt;
            r_hi    <= w_hi_nxt;
            r_guess <= w_mid;
          end
        end

        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.guess  = r_guess;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.found  = r_found;
  assign bus.error  = r_error;
  assign bus.result = r_result;
  assign bus.steps  = r_steps;

endmodule

// File: tb/tb_binary_search_ctrl.sv
// Directed bench for binary_search_ctrl: a behavioural comparator against a
// hidden target, with optional flag overrides for the error scenarios.
module tb_binary_search_ctrl;

  logic clk;
  logic reset;
  int   errs;
  int   checks;

  logic [7:0] target;
  logic       ov_all;      // override flags on every compare
  logic       ov_at_en;    // override flags only when steps == ov_at
  logic [3:0] ov_at;
  logic [2:0] ov_flags;    // {eq, lt, gt}

  binary_search_ctrl_if #(.WIDTH(8)) bus ();

  binary_search_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    if (ov_all || (ov_at_en && (bus.steps == ov_at))) begin
      {bus.eq, bus.lt, bus.gt} = ov_flags;
    end else begin
      bus.eq = (bus.guess == target);
      bus.lt = (bus.guess <  target);
      bus.gt = (bus.guess >  target);
    end
  end

  // Pulses start across one rising edge; returns at the negedge after it.
  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    checks++; if (bus.guess !== 8'd0) begin errs++; $display("FAIL reset_guess got=%0d exp=0", bus.guess); end
    checks++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errs++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.found !== 1'b0) begin errs++; $display("FAIL reset_found got=%b exp=0", bus.found); end
    checks++; if (bus.error !== 1'b0) begin errs++; $display("FAIL reset_error got=%b exp=0", bus.error); end
    checks++; if (bus.result !== 8'd0) begin errs++; $display("FAIL reset_result got=%0d exp=0", bus.result); end
    checks++; if (bus.steps !== 4'd0) begin errs++; $display("FAIL reset_steps got=%0d exp=0", bus.steps); end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({bus.busy, bus.done, bus.guess} !== 10'd0) begin errs++; $display("FAIL idle_hold got=%b/%b/%0d exp=0/0/0", bus.busy, bus.done, bus.guess); end
  endtask

  task automatic test_target_127();
    target = 8'd127;
    pulse_start();
    checks++; if (bus.guess !== 8'd127) begin errs++; $display("FAIL t127_guess got=%0d exp=127", bus.guess); end
    checks++; if (bus.busy !== 1'b1) begin errs++; $display("FAIL t127_busy got=%b exp=1", bus.busy); end
    checks++; if (bus.steps !== 4'd0) begin errs++; $display("FAIL t127_steps0 got=%0d exp=0", bus.steps); end
    @(negedge clk);
    checks++; if ({bus.done, bus.busy, bus.found, bus.error} !== 4'b1010) begin errs++; $display("FAIL t127_status got=%b exp=1010", {bus.done, bus.busy, bus.found, bus.error}); end
    checks++; if (bus.result !== 8'd127) begin errs++; $display("FAIL t127_result got=%0d exp=127", bus.result); end
    checks++; if (bus.steps !== 4'd1) begin errs++; $display("FAIL t127_steps got=%0d exp=1", bus.steps); end
  endtask

  // Also pulses start mid-search; the sequence must be unaffected.
  task automatic test_target_0();
    logic [7:0] seq [8] = '{8'd127, 8'd63, 8'd31, 8'd15, 8'd7, 8'd3, 8'd1, 8'd0};
    target = 8'd0;
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      checks++; if (bus.guess !== seq[i]) begin errs++; $display("FAIL t0_guess[%0d] got=%0d exp=%0d", i, bus.guess, seq[i]); end
      bus.start = (i == 2);
      @(negedge clk);
      bus.start = 1'b0;
    end
    checks++; if ({bus.done, bus.found, bus.error} !== 3'b110) begin errs++; $display("FAIL t0_status got=%b exp=110", {bus.done, bus.found, bus.error}); end
    checks++; if (bus.result !== 8'd0) begin errs++; $display("FAIL t0_result got=%0d exp=0", bus.result); end
    checks++; if (bus.steps !== 4'd8) begin errs++; $display("FAIL t0_steps got=%0d exp=8", bus.steps); end
  endtask

  task automatic test_target_255();
    logic [7:0] seq [9] = '{8'd127, 8'd191, 8'd223, 8'd239, 8'd247, 8'd251, 8'd253, 8'd254, 8'd255};
    target = 8'd255;
    pulse_start();
    for (int i = 0; i < 9; i++) begin
      checks++; if (bus.guess !== seq[i]) begin errs++; $display("FAIL t255_guess[%0d] got=%0d exp=%0d", i, bus.guess, seq[i]); end
      @(negedge clk);
    end
    checks++; if ({bus.done, bus.found, bus.error} !== 3'b110) begin errs++; $display("FAIL t255_status got=%b exp=110", {bus.done, bus.found, bus.error}); end
    checks++; if (bus.result !== 8'd255) begin errs++; $display("FAIL t255_result got=%0d exp=255", bus.result); end
    checks++; if (bus.steps !== 4'd9) begin errs++; $display("FAIL t255_steps got=%0d exp=9", bus.steps); end
    // DONE must hold with no start.
    repeat (4) @(negedge clk);
    checks++; if ({bus.done, bus.found, bus.result, bus.guess} !== {2'b11, 8'd255, 8'd255}) begin errs++; $display("FAIL t255_hold got=%b%b/%0d/%0d exp=11/255/255", bus.done, bus.found, bus.result, bus.guess); end
  endtask

  task automatic test_bad_flags();
    target   = 8'd100;
    ov_at_en = 1'b1;
    ov_at    = 4'd1;
    ov_flags = 3'b011;
    pulse_start();
    repeat (2) @(negedge clk);
    checks++; if ({bus.done, bus.found, bus.error} !== 3'b101) begin errs++; $display("FAIL ltgt_status got=%b exp=101", {bus.done, bus.found, bus.error}); end
    checks++; if (bus.steps !== 4'd2) begin errs++; $display("FAIL ltgt_steps got=%0d exp=2", bus.steps); end
    ov_at    = 4'd0;
    ov_flags = 3'b000;
    pulse_start();
    @(negedge clk);
    checks++; if ({bus.done, bus.found, bus.error} !== 3'b101) begin errs++; $display("FAIL none_status got=%b exp=101", {bus.done, bus.found, bus.error}); end
    checks++; if (bus.steps !== 4'd1) begin errs++; $display("FAIL none_steps got=%0d exp=1", bus.steps); end
    ov_at_en = 1'b0;
  endtask

  task automatic test_forced_lt();
    logic [7:0] seq [9] = '{8'd127, 8'd191, 8'd223, 8'd239, 8'd247, 8'd251, 8'd253, 8'd254, 8'd255};
    target   = 8'd0;
    ov_all   = 1'b1;
    ov_flags = 3'b010;
    pulse_start();
    for (int i = 0; i < 9; i++) begin
      checks++; if (bus.guess !== seq[i]) begin errs++; $display("FAIL flt_guess[%0d] got=%0d exp=%0d", i, bus.guess, seq[i]); end
      @(negedge clk);
    end
    checks++; if ({bus.done, bus.found, bus.error} !== 3'b101) begin errs++; $display("FAIL flt_status got=%b exp=101", {bus.done, bus.found, bus.error}); end
    checks++; if (bus.steps !== 4'd9) begin errs++; $display("FAIL flt_steps got=%0d exp=9", bus.steps); end
    ov_all = 1'b0;
  endtask

  task automatic test_reset_mid();
    target = 8'd0;
    pulse_start();
    repeat (3) @(negedge clk);
    checks++; if (bus.guess !== 8'd15) begin errs++; $display("FAIL rmid_pre_guess got=%0d exp=15", bus.guess); end
    reset = 1'b1;
    #1;
    checks++; if ({bus.busy, bus.done, bus.found, bus.error} !== 4'b0000) begin errs++; $display("FAIL rmid_status got=%b exp=0000", {bus.busy, bus.done, bus.found, bus.error}); end
    checks++; if ({bus.guess, bus.result, bus.steps} !== 20'd0) begin errs++; $display("FAIL rmid_regs got=%0d/%0d/%0d exp=0/0/0", bus.guess, bus.result, bus.steps); end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({bus.busy, bus.done, bus.guess} !== 10'd0) begin errs++; $display("FAIL rmid_idle got=%b/%b/%0d exp=0/0/0", bus.busy, bus.done, bus.guess); end
  endtask

  task automatic test_back_to_back();
    target = 8'd127;
    pulse_start();
    @(negedge clk);
    checks++; if (bus.done !== 1'b1) begin errs++; $display("FAIL b2b_first_done got=%b exp=1", bus.done); end
    target = 8'd191;
    pulse_start();
    checks++; if ({bus.done, bus.busy, bus.found} !== 3'b010) begin errs++; $display("FAIL b2b_restart got=%b exp=010", {bus.done, bus.busy, bus.found}); end
    checks++; if ({bus.guess, bus.steps} !== {8'd127, 4'd0}) begin errs++; $display("FAIL b2b_guess got=%0d/%0d exp=127/0", bus.guess, bus.steps); end
    repeat (2) @(negedge clk);
    checks++; if ({bus.done, bus.found, bus.result, bus.steps} !== {2'b11, 8'd191, 4'd2}) begin errs++; $display("FAIL b2b_second got=%b%b/%0d/%0d exp=11/191/2", bus.done, bus.found, bus.result, bus.steps); end
  endtask

  initial begin
    errs      = 0;
    checks    = 0;
    target    = 8'd0;
    ov_all    = 1'b0;
    ov_at_en  = 1'b0;
    ov_at     = 4'd0;
    ov_flags  = 3'b000;
    bus.start = 1'b0;
    test_reset();
    test_target_127();
    test_target_0();
    test_target_255();
    test_bad_flags();
    test_forced_lt();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
